// File: rtl/counter_sequencer_pkg.sv
// Shared types for the counter sequencer.
// States, run modes and small helpers.
package counter_seq_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ONE_SHOT = 2'b00,
        RELOAD   = 2'b01,
        BOUNCE   = 2'b10
    } mode_e;

    // Mode 2'b11 has no meaning of its own and runs as one-shot.
    function automatic mode_e norm_mode(input logic [1:0] m);
        mode_e r;
        unique case (m)
            2'b01:   r = RELOAD;
            2'b10:   r = BOUNCE;
            default: r = ONE_SHOT;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Bus between the sequencer and the up/down counter.
// master = sequencer side, slave = counter side.
interface counter_sequencer_if #(
    parameter int W = 4
);
    logic [W-1:0] cnt_q;
    logic         cnt_ld;
    logic [W-1:0] cnt_d;
    logic         cnt_up_dn;
    logic         cnt_rst;

    modport master (
        input  cnt_q,
        output cnt_ld,
        output cnt_d,
        output cnt_up_dn,
        output cnt_rst
    );

    modport slave (
        input  cnt_ld,
        input  cnt_d,
        input  cnt_up_dn,
        input  cnt_rst,
        output cnt_q
    );
endinterface

// File: rtl/counter_sequencer.sv
// Sequences an enable-less up/down counter: load, run to a
// target, then stop, reload or bounce under a pass limit.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic                pause,
    input  logic [1:0]          mode,
    input  logic                dir,
    input  logic [W-1:0]        start_val,
    input  logic [W-1:0]        end_val,
    input  logic [3:0]          pass_limit,
    output logic                busy,
    output logic                done,
    output logic [3:0]          passes,
    counter_sequencer_if.master cnt
);

    state_e       state_q, state_d;
    mode_e        mode_q, mode_d;
    logic         dir_q, dir_d;
    logic [W-1:0] start_q, start_d;
    logic [W-1:0] end_q, end_d;
    logic [W-1:0] tgt_q, tgt_d;
    logic [3:0]   limit_q, limit_d;
    logic [3:0]   passes_q, passes_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         terminal;
    logic         limit_hit;
    logic         ld;
    logic [W-1:0] ld_val;

    assign terminal  = (cnt.cnt_q == tgt_q);
    assign limit_hit = (mode_q == ONE_SHOT) ||
                       ((limit_q != 4'd0) &&
                        (({1'b0, passes_q} + 5'd1) ==
                         {1'b0, limit_q}));

    // Next state and counter controls; default is to hold.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        start_d  = start_q;
        end_d    = end_q;
        tgt_d    = tgt_q;
        limit_d  = limit_q;
        passes_d = passes_q;
        done_d   = 1'b0;
        ld       = 1'b1;
        ld_val   = cnt.cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d   = norm_mode(mode);
                    dir_d    = dir;
                    start_d  = start_val;
                    end_d    = end_val;
                    tgt_d    = end_val;
                    limit_d  = pass_limit;
                    passes_d = 4'd0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    ld_val  = start_q;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (terminal) begin
                    passes_d = sat_inc(passes_q);
                    if (limit_hit) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (mode_q == RELOAD) begin
                        ld_val = start_q;
                    end else begin
                        // Bounce: dwell here, then head back.
                        dir_d = ~dir_q;
                        tgt_d = (tgt_q == end_q) ? start_q
                                                 : end_q;
                    end
                end else if (pause) begin
                    state_d = PAUSE;
                end else begin
                    ld = 1'b0;
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    ld      = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // All sequencer state, cleared by the async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mode_q   <= ONE_SHOT;
            dir_q    <= 1'b0;
            start_q  <= '0;
            end_q    <= '0;
            tgt_q    <= '0;
            limit_q  <= 4'd0;
            passes_q <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            start_q  <= start_d;
            end_q    <= end_d;
            tgt_q    <= tgt_d;
            limit_q  <= limit_d;
            passes_q <= passes_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cnt.cnt_ld    = ld;
    assign cnt.cnt_d     = ld_val;
    assign cnt.cnt_up_dn = ~dir_q;
    assign cnt.cnt_rst   = ~reset_n;

    assign busy   = busy_q;
    assign done   = done_q;
    assign passes = passes_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench pairing the sequencer with a 4-bit up/down counter.
// Expected traces come from a rule-level sequence model.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       pause;
    logic [1:0] mode;
    logic       dir;
    logic [3:0] start_val;
    logic [3:0] end_val;
    logic [3:0] pass_limit;
    logic       busy;
    logic       done;
    logic [3:0] passes;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];
    int         exp_passes;
    int         exp_pb;
    bit         exp_fin;

    counter_sequencer_if #(.W(4)) bus ();

    counter_sequencer #(.W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .pause      (pause),
        .mode       (mode),
        .dir        (dir),
        .start_val  (start_val),
        .end_val    (end_val),
        .pass_limit (pass_limit),
        .busy       (busy),
        .done       (done),
        .passes     (passes),
        .cnt        (bus.master)
    );

    always #5 clk = ~clk;

    // The team counter: sync reset, load priority, up_dn=1 down.
    always_ff @(posedge clk) begin
        if (bus.cnt_rst)
            bus.cnt_q <= 4'd0;
        else if (bus.cnt_ld)
            bus.cnt_q <= bus.cnt_d;
        else if (bus.cnt_up_dn)
            bus.cnt_q <= bus.cnt_q - 4'd1;
        else
            bus.cnt_q <= bus.cnt_q + 4'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Value seen in each RUN cycle, straight from the rules.
    task automatic build(input logic [1:0] m, input logic d,
                         input logic [3:0] sv, input logic [3:0] ev,
                         input logic [3:0] lim, input int maxlen);
        int cur, tgt, p;
        bit up, oneshot;
        exp_q.delete();
        cur = sv; tgt = ev; up = d; p = 0;
        exp_fin = 0; exp_pb = 0;
        oneshot = (m == 2'b00) || (m == 2'b11);
        for (int n = 0; n < maxlen; n++) begin
            exp_q.push_back(cur[3:0]);
            exp_pb = p;
            if (cur == tgt) begin
                p = (p < 15) ? p + 1 : 15;
                if (oneshot || (lim != 0 && p == lim)) begin
                    exp_fin = 1;
                    break;
                end
                if (m == 2'b01) begin
                    cur = sv;
                end else begin
                    tgt = (tgt == ev) ? sv : ev;
                    up  = !up;
                end
            end else begin
                cur = (cur + (up ? 1 : 15)) % 16;
            end
        end
        exp_passes = p;
    endtask

    task automatic run_seq(input logic [1:0] m, input logic d,
                           input logic [3:0] sv,
                           input logic [3:0] ev,
                           input logic [3:0] lim,
                           input string name);
        logic [3:0] last;
        build(m, d, sv, ev, lim, 300);
        total++;
        if (!exp_fin) begin
            bad++;
            $display("FAIL %s model: trace did not end", name);
        end
        last = exp_q[exp_q.size() - 1];
        mode = m; dir = d; start_val = sv;
        end_val = ev; pass_limit = lim; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || passes !== 4'd0 ||
            bus.cnt_ld !== 1'b1 || bus.cnt_d !== sv) begin
            bad++;
            $display("FAIL %s load: busy=%b passes=%0d ld=%b d=%0d want 1 0 1 %0d",
                     name, busy, passes, bus.cnt_ld, bus.cnt_d, sv);
        end
        foreach (exp_q[i]) begin
            tick();
            total++;
            if (bus.cnt_q !== exp_q[i] || busy !== 1'b1 ||
                done !== 1'b0) begin
                bad++;
                $display("FAIL %s step %0d: cnt=%0d busy=%b done=%b want %0d 1 0",
                         name, i, bus.cnt_q, busy, done, exp_q[i]);
            end
        end
        tick();
        total++;
        if (done !== 1'b1 || busy !== 1'b0 ||
            passes !== exp_passes[3:0] || bus.cnt_q !== last) begin
            bad++;
            $display("FAIL %s end: done=%b busy=%b passes=%0d cnt=%0d want 1 0 %0d %0d",
                     name, done, busy, passes, bus.cnt_q,
                     exp_passes, last);
        end
        tick();
        total++;
        if (done !== 1'b0 || bus.cnt_q !== last) begin
            bad++;
            $display("FAIL %s idle: done=%b cnt=%0d want 0 %0d",
                     name, done, bus.cnt_q, last);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        pause = 1'b0; mode = 2'b00; dir = 1'b1;
        start_val = 4'd0; end_val = 4'd0; pass_limit = 4'd0;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || passes !== 4'd0 ||
            bus.cnt_rst !== 1'b1 || bus.cnt_q !== 4'd0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b passes=%0d rst=%b cnt=%0d want 0 0 0 1 0",
                     busy, done, passes, bus.cnt_rst, bus.cnt_q);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (bus.cnt_rst !== 1'b0 || bus.cnt_ld !== 1'b1 ||
            bus.cnt_q !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_rel: rst=%b ld=%b cnt=%0d busy=%b want 0 1 0 0",
                     bus.cnt_rst, bus.cnt_ld, bus.cnt_q, busy);
        end
    endtask

    task automatic test_directed();
        run_seq(2'b00, 1'b1, 4'd3, 4'd6, 4'd0, "oneshot_up");
        run_seq(2'b00, 1'b0, 4'd1, 4'd14, 4'd0, "oneshot_wrap");
        run_seq(2'b01, 1'b1, 4'd2, 4'd4, 4'd3, "reload");
        run_seq(2'b10, 1'b1, 4'd5, 4'd7, 4'd4, "bounce");
        run_seq(2'b11, 1'b1, 4'd9, 4'd11, 4'd5, "mode11");
    endtask

    task automatic test_back_to_back();
        run_seq(2'b01, 1'b0, 4'd7, 4'd7, 4'd3, "b2b_equal");
        run_seq(2'b10, 1'b0, 4'd2, 4'd2, 4'd2, "b2b_bnc_eq");
        run_seq(2'b00, 1'b1, 4'd15, 4'd15, 4'd0, "b2b_one");
    endtask

    task automatic test_random();
        logic [1:0] m;
        logic [3:0] sv, ev, lim;
        for (int k = 0; k < 10; k++) begin
            m  = 2'($urandom_range(0, 3));
            sv = 4'($urandom_range(0, 15));
            ev = (k == 0) ? sv : 4'($urandom_range(0, 15));
            if (m == 2'b01 || m == 2'b10)
                lim = 4'($urandom_range(1, 4));
            else
                lim = 4'($urandom_range(0, 4));
            run_seq(m, 1'($urandom_range(0, 1)), sv, ev, lim,
                    "random");
        end
    endtask

    task automatic test_unlimited();
        logic [3:0] last;
        build(2'b01, 1'b1, 4'd14, 4'd1, 4'd0, 20);
        last = exp_q[exp_q.size() - 1];
        mode = 2'b01; dir = 1'b1; start_val = 4'd14;
        end_val = 4'd1; pass_limit = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        foreach (exp_q[i]) begin
            tick();
            total++;
            if (bus.cnt_q !== exp_q[i] || done !== 1'b0) begin
                bad++;
                $display("FAIL unlim step %0d: cnt=%0d done=%b want %0d 0",
                         i, bus.cnt_q, done, exp_q[i]);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 ||
            passes !== exp_pb[3:0] || bus.cnt_q !== last) begin
            bad++;
            $display("FAIL unlim abort: busy=%b done=%b passes=%0d cnt=%0d want 0 0 %0d %0d",
                     busy, done, passes, bus.cnt_q, exp_pb, last);
        end
    endtask

    task automatic test_pause_abort();
        logic [3:0] want[6];
        want = '{4'd4, 4'd4, 4'd4, 4'd5, 4'd5, 4'd5};
        mode = 2'b00; dir = 1'b1; start_val = 4'd2;
        end_val = 4'd9; pass_limit = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; start_val = 4'd12; mode = 2'b01;
        tick();
        start = 1'b0;
        total++;
        if (bus.cnt_q !== 4'd3 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start_ign: cnt=%0d busy=%b want 3 1",
                     bus.cnt_q, busy);
        end
        tick();
        pause = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 2) pause = 1'b0;
            if (i == 3) pause = 1'b1;
            if (i == 4) abort = 1'b1;
            total++;
            if (bus.cnt_q !== want[i] || done !== 1'b0) begin
                bad++;
                $display("FAIL pause %0d: cnt=%0d done=%b want %0d 0",
                         i, bus.cnt_q, done, want[i]);
            end
        end
        abort = 1'b0; pause = 1'b0;
        total++;
        if (busy !== 1'b0 || passes !== 4'd0) begin
            bad++;
            $display("FAIL abort: busy=%b passes=%0d want 0 0",
                     busy, passes);
        end
        tick();
        total++;
        if (bus.cnt_q !== 4'd5 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: cnt=%0d done=%b want 5 0",
                     bus.cnt_q, done);
        end
    endtask

    task automatic test_reset_mid();
        mode = 2'b01; dir = 1'b1; start_val = 4'd0;
        end_val = 4'd1; pass_limit = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (passes !== 4'd2 || bus.cnt_q !== 4'd1) begin
            bad++;
            $display("FAIL mid_pre: passes=%0d cnt=%0d want 2 1",
                     passes, bus.cnt_q);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || passes !== 4'd0 ||
            done !== 1'b0 || bus.cnt_rst !== 1'b1) begin
            bad++;
            $display("FAIL mid_rst: busy=%b passes=%0d done=%b rst=%b want 0 0 0 1",
                     busy, passes, done, bus.cnt_rst);
        end
        tick();
        total++;
        if (bus.cnt_q !== 4'd0) begin
            bad++;
            $display("FAIL mid_cnt: cnt=%0d want 0", bus.cnt_q);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || bus.cnt_q !== 4'd0 ||
            bus.cnt_rst !== 1'b0) begin
            bad++;
            $display("FAIL mid_rel: busy=%b cnt=%0d rst=%b want 0 0 0",
                     busy, bus.cnt_q, bus.cnt_rst);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_unlimited();
        test_pause_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
